inst_prefetch_queue: RTL and testbench

Parametrised successor to the single-slot instruction fetch stage. It keeps up to DEPTH instruction reads in flight on the instruction-memory read port. Returned words are buffered in an in-order queue in front of decode. A redirect (FLUSH/NEW_PC) discards both the queued words and every response still in flight.

---
 rtl/inst_prefetch_queue.sv | 79 +++++++
 tb/tb_inst_prefetch_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: DEPTH-deep instruction prefetch queue with credit-limited issue and redirect discard
module inst_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EXEC,
  input  logic                  STALL,
  input  logic                  FLUSH,
  input  logic [ADDR_WIDTH-1:0] NEW_PC,
  output logic                  MEM_RREQ,
  output logic [ADDR_WIDTH-1:0] MEM_RADDR,
  input  logic                  MEM_RREADY,
  input  logic                  MEM_RVALID,
  input  logic [INST_WIDTH-1:0] MEM_RDATA,
  output logic                  INST_VALID,
  output logic [INST_WIDTH-1:0] INST,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  MEM_WAIT
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [INST_WIDTH-1:0] inst_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding, discard;
  logic [CW+1:0] credits;
  logic [ADDR_WIDTH-1:0] fetch_pc, resp_pc;
  logic issue, push, pop, drop;
  assign credits = {2'b0, count} + {2'b0, outstanding} + {2'b0, discard};
  assign MEM_RREQ = EXEC & ~FLUSH & ~RST & (credits < (CW+2)'(DEPTH));
  assign MEM_RADDR = fetch_pc;
  assign issue = MEM_RREQ & MEM_RREADY;
  assign drop = MEM_RVALID & (discard != '0);
  assign push = MEM_RVALID & (discard == '0) & ~FLUSH & ~RST;
  assign INST_VALID = count != '0;
  assign pop = INST_VALID & ~STALL & ~FLUSH;
  assign INST = INST_VALID ? inst_q[rd_ptr] : '0;
  assign PC = INST_VALID ? pc_q[rd_ptr] : '0;
  assign MEM_WAIT = EXEC & ~INST_VALID;
  always_ff @(posedge CLK) begin
    if (push) begin
      inst_q[wr_ptr] <= MEM_RDATA;
      pc_q[wr_ptr] <= resp_pc;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      outstanding <= '0;
      discard <= '0;
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
    end else if (FLUSH) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      outstanding <= '0;
      discard <= discard + outstanding - CW'(MEM_RVALID);
      fetch_pc <= NEW_PC;
      resp_pc <= NEW_PC;
    end else begin
      if (issue) fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        resp_pc <= resp_pc + ADDR_WIDTH'(4);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(issue) - CW'(push);
      discard <= discard - CW'(drop);
    end
  end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue: directed scenario bench with an in-order variable-latency memory model
module tb_inst_prefetch_queue;
  logic CLK = 0, RST = 1, EXEC = 0, STALL = 0, FLUSH = 0, MEM_RREADY = 1, MEM_RVALID = 0;
  logic [31:0] NEW_PC = '0, MEM_RDATA = '0;
  logic [31:0] MEM_RADDR, INST, PC;
  logic MEM_RREQ, INST_VALID, MEM_WAIT;
  int checks = 0, errors = 0, cyc = 0, lat = 1;
  logic [31:0] pend_addr [$];
  int pend_due [$];
  logic [31:0] issue_log [$];
  always #5 CLK = ~CLK;
  inst_prefetch_queue dut (
    .CLK(CLK), .RST(RST), .EXEC(EXEC), .STALL(STALL), .FLUSH(FLUSH), .NEW_PC(NEW_PC),
    .MEM_RREQ(MEM_RREQ), .MEM_RADDR(MEM_RADDR), .MEM_RREADY(MEM_RREADY),
    .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
    .INST_VALID(INST_VALID), .INST(INST), .PC(PC), .MEM_WAIT(MEM_WAIT)
  );
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h0 ? 32'h3E800093 : a == 32'h4 ? 32'h7D008113 : a == 32'h8 ? 32'hC1810193 : 32'hA0000000 ^ a;
  endfunction
  always @(posedge CLK) cyc++;
  always @(posedge CLK) begin
    if (!RST && MEM_RVALID) begin
      checks++;
      if (int'(dut.outstanding) + int'(dut.discard) == 0) begin errors++; $display("FAIL underflow got out=%0d disc=%0d exp nonzero", dut.outstanding, dut.discard); end
    end
  end
  always @(negedge CLK) begin
    if (RST) begin
      pend_addr.delete();
      pend_due.delete();
      MEM_RVALID = 0;
    end else begin
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        MEM_RVALID = 1;
        MEM_RDATA = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else MEM_RVALID = 0;
      if (MEM_RREQ && MEM_RREADY) begin
        pend_addr.push_back(MEM_RADDR);
        pend_due.push_back(cyc + lat);
        issue_log.push_back(MEM_RADDR);
      end
    end
  end
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic do_reset;
    tick;
    RST = 1; EXEC = 0; STALL = 0; FLUSH = 0; MEM_RREADY = 1;
    tick;
    tick;
    RST = 0;
    issue_log.delete();
  endtask
  task automatic test_reset;
    do_reset;
    #1;
    checks++; if (INST_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", INST_VALID); end
    checks++; if (INST !== 32'h0) begin errors++; $display("FAIL rst_inst got %h exp 0", INST); end
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", PC); end
    checks++; if (MEM_RREQ !== 1'b0) begin errors++; $display("FAIL rst_rreq got %b exp 0", MEM_RREQ); end
    checks++; if (MEM_RADDR !== 32'h0) begin errors++; $display("FAIL rst_raddr got %h exp 0", MEM_RADDR); end
    checks++; if (MEM_WAIT !== 1'b0) begin errors++; $display("FAIL rst_wait got %b exp 0", MEM_WAIT); end
    RST = 1; EXEC = 1;
    #1;
    checks++; if (MEM_RREQ !== 1'b0) begin errors++; $display("FAIL rst_gate_rreq got %b exp 0", MEM_RREQ); end
    tick;
    EXEC = 0; RST = 0;
  endtask
  task automatic test_stream;
    do_reset;
    lat = 1; EXEC = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (MEM_RADDR !== 32'(4 * k)) begin errors++; $display("FAIL stream_raddr%0d got %h exp %h", k, MEM_RADDR, 4 * k); end
      checks++; if (INST_VALID !== (k >= 2)) begin errors++; $display("FAIL stream_valid%0d got %b exp %b", k, INST_VALID, k >= 2); end
      checks++; if (MEM_WAIT !== (k < 2)) begin errors++; $display("FAIL stream_wait%0d got %b exp %b", k, MEM_WAIT, k < 2); end
      if (k >= 2) begin
        checks++; if (PC !== 32'(4 * (k - 2))) begin errors++; $display("FAIL stream_pc%0d got %h exp %h", k, PC, 4 * (k - 2)); end
        checks++; if (INST !== mem_word(32'(4 * (k - 2)))) begin errors++; $display("FAIL stream_inst%0d got %h exp %h", k, INST, mem_word(32'(4 * (k - 2)))); end
      end
      tick;
    end
  endtask
  task automatic test_stall;
    int pops;
    do_reset;
    lat = 1; EXEC = 1; STALL = 1;
    repeat (8) tick;
    #1;
    checks++; if (issue_log.size() != 4) begin errors++; $display("FAIL stall_issues got %0d exp 4", issue_log.size()); end
    checks++; if (MEM_RREQ !== 1'b0) begin errors++; $display("FAIL stall_rreq got %b exp 0", MEM_RREQ); end
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL stall_pc got %h exp 0", PC); end
    checks++; if (INST !== 32'h3E800093) begin errors++; $display("FAIL stall_inst got %h exp 3e800093", INST); end
    STALL = 0;
    pops = 0;
    for (int i = 0; i < 14; i++) begin
      if (INST_VALID) begin
        checks++; if (PC !== 32'(4 * pops)) begin errors++; $display("FAIL drain_pc%0d got %h exp %h", pops, PC, 4 * pops); end
        pops++;
      end
      tick;
      #1;
    end
    checks++; if (pops != 14) begin errors++; $display("FAIL drain_pops got %0d exp 14", pops); end
    for (int i = 0; i < issue_log.size(); i++) begin
      checks++; if (issue_log[i] !== 32'(4 * i)) begin errors++; $display("FAIL drain_req%0d got %h exp %h", i, issue_log[i], 4 * i); end
    end
  endtask
  task automatic test_flush;
    int n;
    do_reset;
    lat = 3; EXEC = 1;
    tick; tick; tick;
    #1;
    checks++; if (dut.outstanding !== 3'd3) begin errors++; $display("FAIL flush_out got %0d exp 3", dut.outstanding); end
    FLUSH = 1; NEW_PC = 32'h100;
    #1;
    checks++; if (MEM_RREQ !== 1'b0) begin errors++; $display("FAIL flush_rreq got %b exp 0", MEM_RREQ); end
    tick;
    FLUSH = 0;
    #1;
    checks++; if (MEM_RADDR !== 32'h100) begin errors++; $display("FAIL flush_raddr got %h exp 100", MEM_RADDR); end
    checks++; if (MEM_RREQ !== 1'b1) begin errors++; $display("FAIL flush_rreq2 got %b exp 1", MEM_RREQ); end
    checks++; if (dut.discard !== 3'd2) begin errors++; $display("FAIL flush_discard got %0d exp 2", dut.discard); end
    n = 0;
    while (!INST_VALID && n < 12) begin tick; #1; n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL flush_wait got %0d exp 4", n); end
    checks++; if (PC !== 32'h100) begin errors++; $display("FAIL flush_pc got %h exp 100", PC); end
    checks++; if (INST !== 32'hA0000100) begin errors++; $display("FAIL flush_inst got %h exp a0000100", INST); end
  endtask
  task automatic test_flush_collide;
    int n;
    do_reset;
    lat = 2; EXEC = 1;
    tick; tick; tick;
    #1;
    checks++; if (INST_VALID !== 1'b1) begin errors++; $display("FAIL coll_valid got %b exp 1", INST_VALID); end
    checks++; if (dut.outstanding !== 3'd2) begin errors++; $display("FAIL coll_out got %0d exp 2", dut.outstanding); end
    FLUSH = 1; NEW_PC = 32'h200;
    @(negedge CLK);
    #1;
    checks++; if (MEM_RVALID !== 1'b1) begin errors++; $display("FAIL coll_rvalid got %b exp 1", MEM_RVALID); end
    tick;
    FLUSH = 0;
    #1;
    checks++; if (INST_VALID !== 1'b0) begin errors++; $display("FAIL coll_empty got %b exp 0", INST_VALID); end
    checks++; if (dut.count !== 3'd0) begin errors++; $display("FAIL coll_count got %0d exp 0", dut.count); end
    checks++; if (dut.discard !== 3'd1) begin errors++; $display("FAIL coll_discard got %0d exp 1", dut.discard); end
    checks++; if (dut.outstanding !== 3'd0) begin errors++; $display("FAIL coll_out2 got %0d exp 0", dut.outstanding); end
    checks++; if (MEM_RADDR !== 32'h200) begin errors++; $display("FAIL coll_raddr got %h exp 200", MEM_RADDR); end
    n = 0;
    while (!INST_VALID && n < 12) begin tick; #1; n++; end
    checks++; if (n != 3) begin errors++; $display("FAIL coll_wait got %0d exp 3", n); end
    checks++; if (PC !== 32'h200) begin errors++; $display("FAIL coll_pc got %h exp 200", PC); end
    checks++; if (INST !== 32'hA0000200) begin errors++; $display("FAIL coll_inst got %h exp a0000200", INST); end
  endtask
  task automatic test_back_to_back;
    int n;
    do_reset;
    lat = 3; EXEC = 1;
    tick; tick;
    FLUSH = 1; NEW_PC = 32'h300;
    tick;
    NEW_PC = 32'h400;
    tick;
    FLUSH = 0;
    #1;
    checks++; if (dut.discard !== 3'd1) begin errors++; $display("FAIL b2b_discard got %0d exp 1", dut.discard); end
    checks++; if (MEM_RADDR !== 32'h400) begin errors++; $display("FAIL b2b_raddr got %h exp 400", MEM_RADDR); end
    n = 0;
    while (!INST_VALID && n < 12) begin tick; #1; n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL b2b_wait got %0d exp 4", n); end
    checks++; if (PC !== 32'h400) begin errors++; $display("FAIL b2b_pc got %h exp 400", PC); end
    checks++; if (INST !== 32'hA0000400) begin errors++; $display("FAIL b2b_inst got %h exp a0000400", INST); end
  endtask
  task automatic test_rready;
    do_reset;
    lat = 1; EXEC = 1; MEM_RREADY = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (MEM_RREQ !== 1'b1) begin errors++; $display("FAIL rdy_rreq%0d got %b exp 1", k, MEM_RREQ); end
      checks++; if (MEM_RADDR !== 32'h0) begin errors++; $display("FAIL rdy_raddr%0d got %h exp 0", k, MEM_RADDR); end
      checks++; if (MEM_WAIT !== 1'b1) begin errors++; $display("FAIL rdy_wait%0d got %b exp 1", k, MEM_WAIT); end
      tick;
    end
    MEM_RREADY = 1;
    tick;
    #1;
    checks++; if (issue_log.size() != 1) begin errors++; $display("FAIL rdy_issues got %0d exp 1", issue_log.size()); end
    checks++; if (MEM_RADDR !== 32'h4) begin errors++; $display("FAIL rdy_raddr_next got %h exp 4", MEM_RADDR); end
    checks++; if (MEM_WAIT !== 1'b1) begin errors++; $display("FAIL rdy_wait_next got %b exp 1", MEM_WAIT); end
    tick;
    #1;
    checks++; if (INST_VALID !== 1'b1) begin errors++; $display("FAIL rdy_valid got %b exp 1", INST_VALID); end
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL rdy_pc got %h exp 0", PC); end
    checks++; if (MEM_WAIT !== 1'b0) begin errors++; $display("FAIL rdy_wait_end got %b exp 0", MEM_WAIT); end
  endtask
  task automatic test_reset_mid;
    int n;
    do_reset;
    lat = 2; EXEC = 1; STALL = 1;
    tick; tick; tick; tick;
    #1;
    checks++; if (dut.count !== 3'd2) begin errors++; $display("FAIL mid_count got %0d exp 2", dut.count); end
    checks++; if (dut.outstanding !== 3'd2) begin errors++; $display("FAIL mid_out got %0d exp 2", dut.outstanding); end
    RST = 1;
    tick;
    #1;
    checks++; if (INST_VALID !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", INST_VALID); end
    checks++; if (INST !== 32'h0) begin errors++; $display("FAIL mid_inst got %h exp 0", INST); end
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL mid_pc got %h exp 0", PC); end
    checks++; if (MEM_RREQ !== 1'b0) begin errors++; $display("FAIL mid_rreq got %b exp 0", MEM_RREQ); end
    checks++; if (MEM_RADDR !== 32'h0) begin errors++; $display("FAIL mid_raddr got %h exp 0", MEM_RADDR); end
    RST = 0; STALL = 0;
    #1;
    checks++; if (MEM_RREQ !== 1'b1) begin errors++; $display("FAIL mid_rreq2 got %b exp 1", MEM_RREQ); end
    n = 0;
    while (!INST_VALID && n < 12) begin tick; #1; n++; end
    checks++; if (n != 3) begin errors++; $display("FAIL mid_wait got %0d exp 3", n); end
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL mid_pc2 got %h exp 0", PC); end
    checks++; if (INST !== 32'h3E800093) begin errors++; $display("FAIL mid_inst2 got %h exp 3e800093", INST); end
  endtask
  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_flush;
    test_flush_collide;
    test_back_to_back;
    test_rready;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
